mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
Shares one 4-input, WIDTH-bit selection path between four requesters using round-robin arbitration. Each requester holds `req_i` with stable data until it receives a one-cycle ack. The winner's data is captured into an output register and presented downstream with a valid/ready handshake. The block sits between four producer blocks and a single consumer.

Parameters:
WIDTH, 4, data width of each requester and of out_data

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
req  in  4  request per requester; held high until the matching ack bit pulses
a  in  WIDTH  requester 0 data
b  in  WIDTH  requester 1 data
c  in  WIDTH  requester 2 data
d  in  WIDTH  requester 3 data
ack  out  4  one-hot, one-cycle pulse: requester's data captured this edge
sel  out  2  index of the requester currently held in out_data
out_data  out  WIDTH  captured data
out_valid  out  1  out_data is valid
out_ready  in  1  consumer accepts when out_valid && out_ready

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: ack=0, sel=0, out_data=0, out_valid=0, ptr=3, state=IDLE.
  - ptr=3 gives requester 0 top priority after reset.
- Arbitration order: scan starts at ptr+1 (mod 4) and takes the first set req bit. ptr becomes the winner's index on capture.
- Capture: on a capture edge the block:
  - loads out_data from the winner's input (sel ? chain: a/b/c/d for 0/1/2/3);
  - sets sel to the winner's index;
  - sets out_valid=1;
  - drives ack[winner]=1 for exactly the next cycle.
- States:
  - IDLE: out_valid=0. If req!=0, capture and go to FULL; else stay in IDLE.
  - FULL: out_valid=1; out_data and sel are held stable while out_ready=0.
    - On out_ready=1 with req!=0: capture the next winner in the same edge and stay in FULL (zero-bubble, one transfer per cycle).
    - On out_ready=1 with req==0: out_valid->0, go to IDLE. out_data keeps its last value.
- Latency: req rising to out_valid is 1 cycle. Ack is asserted in the same cycle out_valid first shows that data.
- Requester rule: a requester must not be re-captured while its ack is high. The arbiter masks req bits whose ack is currently 1, so a requester that drops req one cycle late is never double-served.
- Fairness: with all four requesting continuously, the grant order is 0,1,2,3,0,… Each requester gets one transfer per four accepted transfers.
- Simultaneous events:
  - A req rising in the same cycle as an accept takes part in that arbitration.
  - A req dropping while not acked is legal; that requester is simply not captured.
- Reset mid-operation: the captured word is discarded, no ack is reissued, and ptr returns to 3.
- No arithmetic beyond mod-4 pointer wrap (3+1 -> 0).

Optional Feature:
MUX4_ARB_STATS_EN
- Defined:
  - Adds output `grant_cnt` (4×8 bits, packed, requester 0 in bits [7:0]).
  - Each 8-bit counter increments on that requester's ack pulse and wraps 255->0.
  - All counters clear on rst.
- Undefined: no port and no counters; the remaining behaviour is identical.

Decomposition:
- Package mux4_arb_pkg holds:
  - NUM_REQ=4, IDX_W=2;
  - state enum {IDLE, FULL};
  - the ptr reset constant 3.
- One sub-module, rr_pick4: purely combinational.
  - Inputs: 4-bit request vector (already ack-masked) and 2-bit ptr.
  - Outputs: found bit and 2-bit winner index.
- Top level contains the FSM, data register, ack generation and the optional counters.

Test Plan:
- Single request: after rst, req=0100, c=4'hA, out_ready=1 -> next cycle out_valid=1, out_data=A, sel=2, ack=0100; following cycle out_valid=0, state IDLE.
- Round-robin: req=1111 held, a..d=1,2,3,4, out_ready=1 -> out_data sequence 1,2,3,4,1 on consecutive cycles, ack one-hot rotating, no bubble.
- Backpressure: req=0011, out_ready=0 for 5 cycles -> out_data=a, sel=0 stable, ack pulses once only; on out_ready=1, next cycle out_data=b, sel=1.
- Late req drop: requester 1 keeps req high one cycle after ack -> no second capture of requester 1; with req=0010 only, out_valid falls after accept.
- Reset mid-transfer: out_valid=1, out_ready=0, assert rst one cycle -> out_valid=0, ack=0, out_data=0; then req=1001 -> requester 0 wins first.
- With MUX4_ARB_STATS_EN: 300 accepted transfers from requester 3 only -> grant_cnt[31:24]=44 (wrapped), other counters 0.

Source files
------------

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and constants for the 4-way round-robin mux arbiter.
package mux4_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    // Pointer value that makes requester 0 the first candidate after reset.
    localparam logic [IDX_W-1:0] PTR_RST = 2'd3;

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester-side and consumer-side signals of the 4-way arbiter, bundled as one bus.
interface mux4_rr_arbiter_if #(
    parameter int WIDTH = 4
);
    import mux4_arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [WIDTH-1:0]   c;
    logic [WIDTH-1:0]   d;
    logic [NUM_REQ-1:0] ack;
    logic [IDX_W-1:0]   sel;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;

    modport slave (
        input  req, a, b, c, d, out_ready,
        output ack, sel, out_data, out_valid
    );

    modport master (
        output req, a, b, c, d, out_ready,
        input  ack, sel, out_data, out_valid
    );

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set request bit after ptr, wrapping mod 4.
module rr_pick4
    import mux4_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   win
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ptr + IDX_W'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin 4:1 capture mux with valid/ready output register.
// Optional per-requester grant counters enabled by `define MUX4_ARB_STATS_EN.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mux4_rr_arbiter_if.slave     bus
`ifdef MUX4_ARB_STATS_EN
    ,
    output logic [8*NUM_REQ-1:0] grant_cnt
`endif
);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr;
    logic [NUM_REQ-1:0] req_masked;
    logic               found;
    logic [IDX_W-1:0]   win;
    logic               capture;
    logic               vld_p1;
    logic [WIDTH-1:0]   data_p1;
    logic [IDX_W-1:0]   sel_p1;
    logic [NUM_REQ-1:0] ack_p1;

    function automatic logic [WIDTH-1:0] mux_data(
        input logic [IDX_W-1:0] idx,
        input logic [WIDTH-1:0] da, db, dc, dd
    );
        return (idx == 2'd0) ? da :
               (idx == 2'd1) ? db :
               (idx == 2'd2) ? dc : dd;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

    // A requester whose ack is high this cycle may still show req; never re-serve it.
    assign req_masked = bus.req & ~ack_p1;

    rr_pick4 u_pick (
        .req   (req_masked),
        .ptr   (ptr),
        .found (found),
        .win   (win)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (found) state_nxt = FULL;
            FULL: if (bus.out_ready && !found) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        vld_p1  = (state == FULL);
        capture = found && ((state == IDLE) || bus.out_ready);
    end

    // ---- stage p1: captured word, index and ack pulse ----
    always_ff @(posedge clk) begin
        if (rst) begin
            data_p1 <= '0;
            sel_p1  <= '0;
            ack_p1  <= '0;
            ptr     <= PTR_RST;
        end else begin
            ack_p1 <= capture ? onehot(win) : '0;
            if (capture) begin
                data_p1 <= mux_data(win, bus.a, bus.b, bus.c, bus.d);
                sel_p1  <= win;
                ptr     <= win;
            end
        end
    end

    assign bus.out_data  = data_p1;
    assign bus.sel       = sel_p1;
    assign bus.ack       = ack_p1;
    assign bus.out_valid = vld_p1;

`ifdef MUX4_ARB_STATS_EN
    logic [7:0] cnt [NUM_REQ];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst)            cnt[i] <= '0;
            else if (ack_p1[i]) cnt[i] <= cnt[i] + 8'd1;
        end
    end

    assign grant_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter; grant counters checked when MUX4_ARB_STATS_EN is defined.
module tb_mux4_rr_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    mux4_rr_arbiter_if #(.WIDTH(4)) bus ();

`ifdef MUX4_ARB_STATS_EN
    logic [31:0] grant_cnt;
`endif

    mux4_rr_arbiter #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef MUX4_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic vld, input logic [3:0] data,
                           input logic [1:0] sel, input logic [3:0] ack);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'(vld));
        chk({tag, "_data"},  32'(bus.out_data),  32'(data));
        chk({tag, "_sel"},   32'(bus.sel),       32'(sel));
        chk({tag, "_ack"},   32'(bus.ack),       32'(ack));
    endtask

    initial begin
        rst = 1'b1;
        bus.req = 4'b0000;
        bus.a = 4'h0; bus.b = 4'h0; bus.c = 4'h0; bus.d = 4'h0;
        bus.out_ready = 1'b0;
        step();
        step();
        chk_out("reset", 1'b0, 4'h0, 2'd0, 4'b0000);
`ifdef MUX4_ARB_STATS_EN
        chk("reset_cnt", grant_cnt, 32'h0);
`endif

        // Single request from requester 2
        rst = 1'b0;
        bus.c = 4'hA; bus.req = 4'b0100; bus.out_ready = 1'b1;
        step();
        chk_out("single_cap", 1'b1, 4'hA, 2'd2, 4'b0100);
        bus.req = 4'b0000;
        step();
        chk_out("single_idle", 1'b0, 4'hA, 2'd2, 4'b0000);

        // Round-robin, all requesting, starting from a fresh pointer
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.a = 4'h1; bus.b = 4'h2; bus.c = 4'h3; bus.d = 4'h4;
        bus.req = 4'b1111; bus.out_ready = 1'b1;
        step(); chk_out("rr0", 1'b1, 4'h1, 2'd0, 4'b0001);
        step(); chk_out("rr1", 1'b1, 4'h2, 2'd1, 4'b0010);
        step(); chk_out("rr2", 1'b1, 4'h3, 2'd2, 4'b0100);
        step(); chk_out("rr3", 1'b1, 4'h4, 2'd3, 4'b1000);
        step(); chk_out("rr4", 1'b1, 4'h1, 2'd0, 4'b0001);

        // Backpressure: requester 0 captured and held while consumer stalls
        rst = 1'b1; bus.req = 4'b0000;
        step();
        rst = 1'b0;
        bus.a = 4'h5; bus.b = 4'h6;
        bus.req = 4'b0011; bus.out_ready = 1'b0;
        step();
        chk_out("bp_cap", 1'b1, 4'h5, 2'd0, 4'b0001);
        bus.req = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out("bp_hold", 1'b1, 4'h5, 2'd0, 4'b0000);
        end
        bus.out_ready = 1'b1;
        step();
        chk_out("bp_next", 1'b1, 4'h6, 2'd1, 4'b0010);

        // Requester 1 drops req one cycle late: must not be captured twice
        step();
        chk_out("late_drop", 1'b0, 4'h6, 2'd1, 4'b0000);
        bus.req = 4'b0000;
        step();
        chk_out("late_idle", 1'b0, 4'h6, 2'd1, 4'b0000);

        // Reset while a word is held, then requester 0 wins over 3
        bus.c = 4'hA; bus.req = 4'b0100; bus.out_ready = 1'b0;
        step();
        chk_out("mid_cap", 1'b1, 4'hA, 2'd2, 4'b0100);
        bus.req = 4'b0000;
        rst = 1'b1;
        step();
        chk_out("mid_rst", 1'b0, 4'h0, 2'd0, 4'b0000);
        rst = 1'b0;
        bus.a = 4'h7; bus.d = 4'h8; bus.req = 4'b1001; bus.out_ready = 1'b1;
        step();
        chk_out("post_rst", 1'b1, 4'h7, 2'd0, 4'b0001);
        bus.req = 4'b1000;
        step();
        chk_out("post_rst2", 1'b1, 4'h8, 2'd3, 4'b1000);
        bus.req = 4'b0000;
        step();

`ifdef MUX4_ARB_STATS_EN
        begin
            int acks = 0;
            int guard = 0;
            rst = 1'b1;
            step();
            rst = 1'b0;
            bus.req = 4'b1000; bus.out_ready = 1'b1;
            while (acks < 300 && guard < 2000) begin
                step();
                guard++;
                if (bus.ack[3]) acks++;
            end
            chk("stats_acks", 32'(acks), 32'd300);
            bus.req = 4'b0000;
            step();
            chk("stats_cnt", grant_cnt, {8'd44, 8'd0, 8'd0, 8'd0});
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
